// File: rtl/c2h_byp_st_arb.sv
// Round-robin arbiter for two C2H ST bypass descriptor requesters, with a
// 2-entry registered output buffer. Define C2H_BYP_ARB_STATS_EN to build the grant counters.
module c2h_byp_st_arb #(
  parameter int ADDR_W = 64,
  parameter int QID_W  = 11,
  parameter int FUNC_W = 12
) (
  input  logic              axi_aclk,
  input  logic              axi_aresetn,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [QID_W-1:0]  r0_qid,
  input  logic [FUNC_W-1:0] r0_func,
  input  logic [2:0]        r0_port_id,
  input  logic [6:0]        r0_pfch_tag,
  input  logic              r0_error,
  input  logic              r0_vld,
  output logic              r0_rdy,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [QID_W-1:0]  r1_qid,
  input  logic [FUNC_W-1:0] r1_func,
  input  logic [2:0]        r1_port_id,
  input  logic [6:0]        r1_pfch_tag,
  input  logic              r1_error,
  input  logic              r1_vld,
  output logic              r1_rdy,
  input  logic              arb_pause,
  output logic [ADDR_W-1:0] m_addr,
  output logic [QID_W-1:0]  m_qid,
  output logic [FUNC_W-1:0] m_func,
  output logic [2:0]        m_port_id,
  output logic [6:0]        m_pfch_tag,
  output logic              m_error,
  output logic              m_src,
  output logic              m_vld,
  input  logic              m_rdy,
  output logic [15:0]       gnt_cnt0,
  output logic [15:0]       gnt_cnt1
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [QID_W-1:0]  qid;
    logic [FUNC_W-1:0] func;
    logic [2:0]        port_id;
    logic [6:0]        pfch_tag;
    logic              error;
    logic              src;
  } entry_t;

  entry_t     mem_q [2];
  entry_t     mem_d [2];
  entry_t     push_entry;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       last_q, last_d;
  logic       pop, push, space, can_gnt, gnt0, gnt1;

  always_comb begin
    pop     = (count_q != 2'd0) & m_rdy;
    space   = (count_q != 2'd2) | pop;
    can_gnt = space & ~arb_pause & axi_aresetn;
    // On contention the requester that did not win last time goes next.
    gnt0    = can_gnt & r0_vld & (~r1_vld | last_q);
    gnt1    = can_gnt & r1_vld & (~r0_vld | ~last_q);
    push    = gnt0 | gnt1;

    if (gnt1)
      push_entry = '{addr: r1_addr, qid: r1_qid, func: r1_func, port_id: r1_port_id,
                     pfch_tag: r1_pfch_tag, error: r1_error, src: 1'b1};
    else
      push_entry = '{addr: r0_addr, qid: r0_qid, func: r0_func, port_id: r0_port_id,
                     pfch_tag: r0_pfch_tag, error: r0_error, src: 1'b0};

    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    if (push) mem_d[wr_ptr_q] = push_entry;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    last_d   = push ? gnt1 : last_q;
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      last_q   <= 1'b1;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  assign r0_rdy     = gnt0;
  assign r1_rdy     = gnt1;
  assign m_vld      = (count_q != 2'd0);
  assign m_addr     = mem_q[rd_ptr_q].addr;
  assign m_qid      = mem_q[rd_ptr_q].qid;
  assign m_func     = mem_q[rd_ptr_q].func;
  assign m_port_id  = mem_q[rd_ptr_q].port_id;
  assign m_pfch_tag = mem_q[rd_ptr_q].pfch_tag;
  assign m_error    = mem_q[rd_ptr_q].error;
  assign m_src      = mem_q[rd_ptr_q].src;

`ifdef C2H_BYP_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = (gnt0 && cnt0_q != 16'hFFFF) ? cnt0_q + 16'd1 : cnt0_q;
    cnt1_d = (gnt1 && cnt1_q != 16'hFFFF) ? cnt1_q + 16'd1 : cnt1_q;
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      cnt0_q <= 16'h0000;
      cnt1_q <= 16'h0000;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`else
  assign gnt_cnt0 = 16'h0000;
  assign gnt_cnt1 = 16'h0000;
`endif

endmodule
